// File: rtl/keystone_pkg.sv
// Shared types and constants for the keystone frame controller.
// Coefficients are Q16.16 signed; index 0 is H11, index 7 is H32.
package keystone_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int NUM_COEF = 8;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  localparam int IDX_H11 = 0;
  localparam int IDX_H12 = 1;
  localparam int IDX_H13 = 2;
  localparam int IDX_H21 = 3;
  localparam int IDX_H22 = 4;
  localparam int IDX_H23 = 5;
  localparam int IDX_H31 = 6;
  localparam int IDX_H32 = 7;

  // Packed most-significant first, so the rightmost entry is H11.
  localparam logic [NUM_COEF-1:0][31:0] IDENTITY =
    {ZERO, ZERO, ZERO, ONE, ZERO, ZERO, ZERO, ONE};

endpackage

// File: rtl/keystone_frame_ctrl_if.sv
// Tap on the Keystone input stream plus the upstream stall request.
interface keystone_frame_ctrl_if;
  logic mon_tvalid;
  logic mon_tready;
  logic mon_tuser;
  logic mon_tlast;
  logic stall_req;

  modport master (output mon_tvalid, mon_tready, mon_tuser, mon_tlast,
                  input  stall_req);
  modport slave  (input  mon_tvalid, mon_tready, mon_tuser, mon_tlast,
                  output stall_req);
endinterface

// File: rtl/keystone_stream_mon.sv
// Passive stream monitor: beat/SOF decode, line-open tracking, frame counter
// and the sticky start-of-frame-inside-a-line error.
module keystone_stream_mon #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tvalid,
  input  logic                   tready,
  input  logic                   tuser,
  input  logic                   tlast,
  input  logic                   err_clear,
  output logic                   sof_beat,
  output logic                   line_open,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_sof_midline
);

  logic                   beat;
  logic                   open_q, open_d;
  logic [FRAME_CNT_W-1:0] fc_q, fc_d;
  logic                   err_q, err_d;

  assign beat     = tvalid & tready;
  assign sof_beat = beat & tuser;

  always_comb begin
    open_d = open_q;
    fc_d   = fc_q;
    err_d  = err_q;
    if (beat) open_d = ~tlast;
    if (sof_beat) fc_d = fc_q + FRAME_CNT_W'(1);
    // Set wins over a coincident clear.
    if (sof_beat && open_q) err_d = 1'b1;
    else if (err_clear)     err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= 1'b0;
      fc_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      fc_q   <= fc_d;
      err_q  <= err_d;
    end
  end

  assign line_open       = open_q;
  assign frame_count     = fc_q;
  assign err_sof_midline = err_q;

endmodule

// File: rtl/keystone_frame_ctrl.sv
// Keystone frame controller: frame-synchronous coefficient commit and
// enable changes sequenced through a drain/flush of the Keystone core.
//   state | meaning
//   RUN   | enable matches request, coefficients applied on SOF
//   DRAIN | enable change requested, waiting for the open line to close
//   FLUSH | stall upstream and hold SW_RESET; enable updates on last cycle
module keystone_frame_ctrl
  import keystone_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int FLUSH_CYCLES       = 4,
  parameter int FRAME_CNT_W        = 16
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [NUM_COEF-1:0][C_S_AXI_DATA_WIDTH-1:0] cfg_h,
  input  logic                                        cfg_commit,
  input  logic                                        cfg_enable,
  keystone_frame_ctrl_if.slave                        mon,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H11,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H12,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H13,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H21,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H22,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H23,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H31,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               H32,
  output logic                                        ENABLE_KEYSTONE,
  output logic                                        SW_RESET,
  output logic                                        commit_pending,
  output logic                                        commit_done,
  output logic [FRAME_CNT_W-1:0]                      frame_count,
  output logic                                        err_sof_midline,
  input  logic                                        err_clear
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic sof_beat;
  logic line_open;

  keystone_stream_mon #(.FRAME_CNT_W(FRAME_CNT_W)) u_mon (
    .clk             (aclk),
    .rst             (areset),
    .tvalid          (mon.mon_tvalid),
    .tready          (mon.mon_tready),
    .tuser           (mon.mon_tuser),
    .tlast           (mon.mon_tlast),
    .err_clear       (err_clear),
    .sof_beat        (sof_beat),
    .line_open       (line_open),
    .frame_count     (frame_count),
    .err_sof_midline (err_sof_midline)
  );

  logic [NUM_COEF-1:0][DW-1:0] h_q, h_d, stage_q, stage_d;
  logic                        pending_q, pending_d;
  logic                        done_q, done_d;

  // Apply uses the staging value from before a coincident commit.
  always_comb begin
    h_d       = h_q;
    stage_d   = stage_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (sof_beat && pending_q) begin
      h_d       = stage_q;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end
    if (cfg_commit) begin
      stage_d   = cfg_h;
      pending_d = 1'b1;
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_enable != en_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cfg_enable == en_q) begin
          state_d = ST_RUN;
        end else if (!line_open) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          en_d    = cfg_enable;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        h_q[i]     <= DW'(IDENTITY[i]);
        stage_q[i] <= DW'(IDENTITY[i]);
      end
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      en_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
    end
  end

  assign mon.stall_req     = (state_q == ST_FLUSH);
  assign SW_RESET          = (state_q == ST_FLUSH);
  assign ENABLE_KEYSTONE   = en_q;
  assign commit_pending    = pending_q;
  assign commit_done       = done_q;

  assign H11 = h_q[IDX_H11];
  assign H12 = h_q[IDX_H12];
  assign H13 = h_q[IDX_H13];
  assign H21 = h_q[IDX_H21];
  assign H22 = h_q[IDX_H22];
  assign H23 = h_q[IDX_H23];
  assign H31 = h_q[IDX_H31];
  assign H32 = h_q[IDX_H32];

endmodule

// File: doc/keystone_frame_ctrl.md
KEYSTONE_FRAME_CTRL -- requirements
Module: keystone_frame_ctrl

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, coefficient word width (Q16.16 signed).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 4, number of cycles SW_RESET is held per flush.
REQ-003 SHALL have parameter FRAME_CNT_W, default 16, frame counter width.
REQ-004 SHALL have port aclk, input, 1, sole clock.
REQ-005 SHALL have port areset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_h, input, 8 x C_S_AXI_DATA_WIDTH, host coefficients in order H11,H12,H13,H21,H22,H23,H31,H32.
REQ-007 SHALL have port cfg_commit, input, 1, one-cycle pulse that stages cfg_h.
REQ-008 SHALL have port cfg_enable, input, 1, requested keystone enable level.
REQ-009 SHALL have ports mon_tvalid, mon_tready, mon_tuser, mon_tlast, each input, 1, tap on the Keystone input AXI4-Stream.
REQ-010 SHALL have ports H11..H32, each output, C_S_AXI_DATA_WIDTH, active coefficients to Keystone.
REQ-011 SHALL have ports ENABLE_KEYSTONE and SW_RESET, each output, 1, to Keystone.
REQ-012 SHALL have port stall_req, output, 1; when high, upstream must hold tready low.
REQ-013 SHALL have ports commit_pending (level) and commit_done (one-cycle pulse), each output, 1.
REQ-014 SHALL have port frame_count, output, FRAME_CNT_W, SOF beats accepted, wrapping.
REQ-015 SHALL have port err_sof_midline, output, 1, sticky; and port err_clear, input, 1, clears it.

Function
REQ-016 Beat SHALL mean mon_tvalid & mon_tready in the same cycle; SOF beat = beat & mon_tuser.
REQ-017 On cfg_commit, cfg_h SHALL be copied to the staging registers and commit_pending set the next cycle.
REQ-018 On an SOF beat while commit_pending=1, staging SHALL be copied to H11..H32 on that edge, commit_pending cleared, and commit_done pulsed in the following cycle.
REQ-019 A cfg_commit while pending SHALL overwrite staging; the latest commit wins and the pending flag stays set.
REQ-020 A cfg_commit coincident with an applying SOF beat SHALL apply the old staging, capture the new value, and leave commit_pending=1.
REQ-021 Enable FSM states: RUN, DRAIN, FLUSH.
- RUN -> DRAIN when cfg_enable != ENABLE_KEYSTONE.
- DRAIN -> FLUSH on the first cycle where the line is not open; open = a beat occurred since the last tlast beat.
- FLUSH: stall_req=1 and SW_RESET=1 for exactly FLUSH_CYCLES cycles; on the last cycle, ENABLE_KEYSTONE takes the cfg_enable value sampled then -> RUN.
REQ-022 stall_req SHALL assert on DRAIN->FLUSH edge; a beat in that same cycle SHALL still be counted.
REQ-023 If cfg_enable reverts during DRAIN, the FSM SHALL return to RUN with no flush.
REQ-024 frame_count SHALL increment on each SOF beat, wrapping at 2^FRAME_CNT_W-1 -> 0.
REQ-025 An SOF beat while the line is open SHALL set err_sof_midline; the open state is restarted by that beat.
REQ-026 err_clear SHALL clear err_sof_midline; simultaneous set and clear SHALL leave it set.
REQ-027 The block SHALL be transparent to data; it never drives stream signals except via stall_req.

Reset
REQ-028 areset SHALL be applied asynchronously with synchronous deassertion handled upstream.
REQ-029 On reset, H11..H32 and staging SHALL be identity (H11=H22=32'h0001_0000, others 0); ENABLE_KEYSTONE=0; SW_RESET=0; stall_req=0.
REQ-030 On reset, commit_pending=0, commit_done=0, frame_count=0, err_sof_midline=0, line closed, FSM=RUN.
REQ-031 Reset mid-FLUSH SHALL abort the flush immediately with the reset values above.

Structure
REQ-032 Package keystone_pkg SHALL hold the FSM state enum, the Q16.16 constants ONE and ZERO, the coefficient index constants, and the identity coefficient array.
REQ-033 Sub-module keystone_stream_mon SHALL hold beat/SOF decode, the line-open flag, frame_count, and the error flag; the FSM and coefficient registers live in the top level.

Verification
REQ-034 Commit H13=32'h0005_0000 mid-frame, then SOF beat -> H13 changes on the SOF edge, commit_done pulses once, and commit_pending falls.
REQ-035 Two commits (H11=0x2_0000, then 0x3_0000) before SOF -> only 0x3_0000 is applied.
REQ-036 cfg_enable 0->1 mid-line -> DRAIN until tlast beat, then SW_RESET and stall_req high 4 cycles, then ENABLE_KEYSTONE=1.
REQ-037 SOF beat with no preceding tlast after a beat -> err_sof_midline=1; err_clear -> 0.
REQ-038 Assert areset during cycle 2 of FLUSH -> all outputs at reset values in the same cycle and H11=0x1_0000.
REQ-039 2^16 SOF beats -> frame_count wraps to 0.
